// File: rtl/pll_seq_pkg.sv
// Shared types and phase arithmetic for the PLL phase sequencer.
// Phase positions are 8 bits wide and are masked to the configured turn size.
package pll_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SWITCH,
      ST_SETTLE,
      ST_PLAN,
      ST_STEP_ARM,
      ST_STEP_HOLD,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_DONE
   } seq_state_t;

   localparam logic [2:0] CNT_SEL_ALL = 3'b000;

   typedef struct packed {
      logic       up;
      logic [8:0] n;
   } step_plan_t;

   // Shortest way round the ring. An exact half turn goes up.
   function automatic step_plan_t plan_steps(input logic [7:0] cur, input logic [7:0] tgt,
                                             input int unsigned steps);
      logic [7:0] d;
      step_plan_t p;
      d    = (tgt - cur) & 8'(steps - 1);
      p.up = 1'b1;
      p.n  = {1'b0, d};
      if ({1'b0, d} > 9'(steps / 2)) begin
         p.up = 1'b0;
         p.n  = 9'(steps) - {1'b0, d};
      end
      return p;
   endfunction

   function automatic logic [7:0] phase_step(input logic [7:0] cur, input logic up,
                                             input int unsigned steps);
      return (up ? cur + 8'd1 : cur - 8'd1) & 8'(steps - 1);
   endfunction

endpackage

// File: rtl/pll_phase_sequencer_scanclk_gen.sv
// Free-running scanclk divider; rise/fall strobes are high in the first clk cycle after each edge.
// Fixed latency, no backpressure: runs from reset onwards regardless of the sequencer state.
module scanclk_gen #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_scanclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DW-1:0] r_div;
   logic          r_sclk;
   logic          r_rise;
   logic          r_fall;
   logic          w_tick;

   assign w_tick = (r_div == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_div  <= w_tick ? '0 : r_div + 1'b1;
         r_sclk <= w_tick ? ~r_sclk : r_sclk;
         r_rise <= w_tick & ~r_sclk;
         r_fall <= w_tick & r_sclk;
      end
   end

   assign o_scanclk = r_sclk;
   assign o_rise    = r_rise;
   assign o_fall    = r_fall;

endmodule

// File: rtl/pll_phase_sequencer.sv
// ALTPLL reconfig sequencer: optional clkswitch + settle, then shortest-path phase steps.
// ~6*SCAN_DIV clk per step plus PLL phasedone time; requests while busy park in a 1-deep slot, last wins.
module pll_phase_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 4,
   parameter int unsigned PHASE_STEPS    = 64,
   parameter logic [2:0]  CNT_SEL        = CNT_SEL_ALL,
   parameter int unsigned SWITCH_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES  = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       updatepll,
   input  logic       pll_clk_src,
   input  logic [7:0] pll_clk_phase,
   input  logic       phasedone,
   output logic       scanclk,
   output logic [2:0] phasecounterselect,
   output logic       phaseupdown,
   output logic       phasestep,
   output logic       clkswitch,
   output logic       busy,
   output logic       done,
   output logic [7:0] cur_phase,
   output logic       cur_src,
   output logic       err_timeout
);

   seq_state_t r_state, w_state_nxt;
   logic [15:0] r_cnt;
   logic [1:0]  r_rcnt;
   logic [8:0]  r_nsteps;
   logic [7:0]  r_tgt, r_pend_phase, r_cur_phase;
   logic        r_tsrc, r_pend_vld, r_pend_src, r_cur_src;
   logic        r_phaseupdown, r_phasestep, r_clkswitch, r_busy, r_done, r_err;
   logic        r_pd_meta, r_pd_sync;
   logic        w_rise, w_fall, w_scanclk;
   logic        w_accept, w_step_ok, w_tmo, w_wait_tmo, w_req_src;
   logic [7:0]  w_req_phase;
   step_plan_t  w_plan;

   scanclk_gen #(.SCAN_DIV(SCAN_DIV)) u_scanclk (
      .clk       (clk),
      .rst_n     (rst_n),
      .o_scanclk (w_scanclk),
      .o_rise    (w_rise),
      .o_fall    (w_fall)
   );

   assign w_req_phase = updatepll ? pll_clk_phase : r_pend_phase;
   assign w_req_src   = updatepll ? pll_clk_src : r_pend_src;
   assign w_plan      = plan_steps(r_cur_phase, r_tgt, PHASE_STEPS);
   assign w_wait_tmo  = (r_cnt == 16'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step_ok   = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (updatepll || r_pend_vld) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_req_src != r_cur_src) ? ST_SWITCH : ST_PLAN;
            end
         end
         ST_SWITCH:    if (r_cnt == 16'(SWITCH_CYCLES - 1)) w_state_nxt = ST_SETTLE;
         ST_SETTLE:    if (r_cnt == 16'(SETTLE_CYCLES - 1)) w_state_nxt = ST_PLAN;
         ST_PLAN:      w_state_nxt = (w_plan.n == 9'd0) ? ST_DONE : ST_STEP_ARM;
         ST_STEP_ARM:  if (w_fall) w_state_nxt = ST_STEP_HOLD;
         ST_STEP_HOLD: if (w_fall && r_rcnt == 2'd2) w_state_nxt = ST_WAIT_LO;
         ST_WAIT_LO: begin
            if (!r_pd_sync) w_state_nxt = ST_WAIT_HI;
            else if (w_wait_tmo) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_WAIT_HI: begin
            if (r_pd_sync) begin
               w_step_ok   = 1'b1;
               w_state_nxt = (r_nsteps == 9'd1) ? ST_DONE : ST_STEP_ARM;
            end else if (w_wait_tmo) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_rcnt        <= '0;
         r_nsteps      <= '0;
         r_tgt         <= '0;
         r_tsrc        <= 1'b0;
         r_pend_vld    <= 1'b0;
         r_pend_phase  <= '0;
         r_pend_src    <= 1'b0;
         r_cur_phase   <= '0;
         r_cur_src     <= 1'b0;
         r_phaseupdown <= 1'b1;
         r_phasestep   <= 1'b0;
         r_clkswitch   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_pd_meta     <= 1'b1;
         r_pd_sync     <= 1'b1;
      end else begin
         r_pd_meta <= phasedone;
         r_pd_sync <= r_pd_meta;
         r_cnt     <= (w_state_nxt != r_state) ? '0 : r_cnt + 16'd1;

         if (w_accept) begin
            r_tgt      <= w_req_phase & 8'(PHASE_STEPS - 1);
            r_tsrc     <= w_req_src;
            r_pend_vld <= 1'b0;
         end else if (updatepll) begin
            r_pend_vld   <= 1'b1;
            r_pend_phase <= pll_clk_phase;
            r_pend_src   <= pll_clk_src;
         end

         if (r_state == ST_SWITCH && w_state_nxt == ST_SETTLE) r_cur_src <= r_tsrc;

         if (r_state == ST_PLAN && w_plan.n != 9'd0) begin
            r_phaseupdown <= w_plan.up;
            r_nsteps      <= w_plan.n;
         end

         if (r_state == ST_STEP_ARM) r_rcnt <= '0;
         else if (r_state == ST_STEP_HOLD && w_rise && r_rcnt != 2'd3) r_rcnt <= r_rcnt + 2'd1;

         if (w_step_ok) begin
            r_cur_phase <= phase_step(r_cur_phase, r_phaseupdown, PHASE_STEPS);
            r_nsteps    <= r_nsteps - 9'd1;
         end
         if (w_tmo) r_err <= 1'b1;

         r_phasestep <= (w_state_nxt == ST_STEP_HOLD);
         r_clkswitch <= (w_state_nxt == ST_SWITCH);
         r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   assign scanclk            = w_scanclk;
   assign phasecounterselect = CNT_SEL;
   assign phaseupdown        = r_phaseupdown;
   assign phasestep          = r_phasestep;
   assign clkswitch          = r_clkswitch;
   assign busy               = r_busy;
   assign done               = r_done;
   assign cur_phase          = r_cur_phase;
   assign cur_src            = r_cur_src;
   assign err_timeout        = r_err;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Directed bench for pll_phase_sequencer with a behavioural PLL phasedone model.
module tb_pll_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       updatepll = 1'b0;
   logic       pll_clk_src = 1'b0;
   logic [7:0] pll_clk_phase = 8'd0;
   logic       phasedone = 1'b1;
   logic       scanclk, phaseupdown, phasestep, clkswitch, busy, done, cur_src, err_timeout;
   logic [2:0] phasecounterselect;
   logic [7:0] cur_phase;

   always #5 clk = ~clk;

   pll_phase_sequencer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .updatepll          (updatepll),
      .pll_clk_src        (pll_clk_src),
      .pll_clk_phase      (pll_clk_phase),
      .phasedone          (phasedone),
      .scanclk            (scanclk),
      .phasecounterselect (phasecounterselect),
      .phaseupdown        (phaseupdown),
      .phasestep          (phasestep),
      .clkswitch          (clkswitch),
      .busy               (busy),
      .done               (done),
      .cur_phase          (cur_phase),
      .cur_src            (cur_src),
      .err_timeout        (err_timeout)
   );

   int n_vec = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // PLL model: phasedone drops 3 scanclk edges after phasestep rises, recovers 8 edges later.
   logic m_dead = 1'b0;
   logic m_active = 1'b0;
   logic m_ps_q = 1'b0;
   logic m_sc_q = 1'b0;
   int   m_edges = 0;
   always @(negedge clk) begin
      if (m_active && scanclk != m_sc_q) begin
         m_edges++;
         if (m_edges == 3 && !m_dead) phasedone = 1'b0;
         if (m_edges == 11) begin
            phasedone = 1'b1;
            m_active  = 1'b0;
         end
      end
      if (!m_active && phasestep && !m_ps_q) begin
         m_active = 1'b1;
         m_edges  = 0;
      end
      m_ps_q = phasestep;
      m_sc_q = scanclk;
   end

   // Monitor: step/pulse counters, event timestamps and sticky protocol flags.
   int   cyc = 0, up_steps = 0, dn_steps = 0, sw_cycles = 0, done_cnt = 0;
   int   ps_rises = 0, ps_fall_cyc = 0, sw_fall_cyc = 0, done_cyc = 0;
   logic ps_q = 1'b0, sc_q = 1'b0, sw_q = 1'b0, ps_pud = 1'b1;
   logic hold_short = 1'b0, pud_bad = 1'b0, range_bad = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (clkswitch) sw_cycles++;
      if (!clkswitch && sw_q) sw_fall_cyc = cyc;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (phasestep && !ps_q) begin
         if (phaseupdown) up_steps++;
         else dn_steps++;
         ps_pud   = phaseupdown;
         ps_rises = 0;
      end
      if (phasestep && scanclk && !sc_q) ps_rises++;
      if (phasestep && phaseupdown != ps_pud) pud_bad = 1'b1;
      if (!phasestep && ps_q) begin
         ps_fall_cyc = cyc;
         if (rst_n && ps_rises < 2) hold_short = 1'b1;
      end
      if (cur_phase >= 8'd64) range_bad = 1'b1;
      ps_q = phasestep;
      sc_q = scanclk;
      sw_q = clkswitch;
   end

   int b_up, b_dn, b_sw, b_done;

   task automatic snap();
      b_up   = up_steps;
      b_dn   = dn_steps;
      b_sw   = sw_cycles;
      b_done = done_cnt;
   endtask

   task automatic do_req(input logic src, input logic [7:0] ph);
      @(negedge clk);
      pll_clk_src   = src;
      pll_clk_phase = ph;
      updatepll     = 1'b1;
      @(negedge clk);
      updatepll     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < max_cyc);
      check_val(tag, done, 1'b1);
   endtask

   initial begin
      // T1: reset state, then 0 -> 5 going up
      repeat (3) @(negedge clk);
      check_val("rst_scanclk", scanclk, 0);
      check_val("rst_phasestep", phasestep, 0);
      check_val("rst_phaseupdown", phaseupdown, 1);
      check_val("rst_cntsel", phasecounterselect, 0);
      check_val("rst_clkswitch", clkswitch, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_cur_phase", cur_phase, 0);
      check_val("rst_cur_src", cur_src, 0);
      check_val("rst_err", err_timeout, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      snap();
      do_req(1'b0, 8'd5);
      check_val("t1_busy", busy, 1);
      wait_done("t1_done", 4000);
      check_val("t1_busy_at_done", busy, 0);
      repeat (5) @(negedge clk);
      check_val("t1_up", up_steps - b_up, 5);
      check_val("t1_dn", dn_steps - b_dn, 0);
      check_val("t1_phase", cur_phase, 5);
      check_val("t1_sw", sw_cycles - b_sw, 0);
      check_val("t1_done_cnt", done_cnt - b_done, 1);

      // T2: 5 -> 60 is 9 steps down through 0
      snap();
      do_req(1'b0, 8'd60);
      wait_done("t2_done", 4000);
      repeat (3) @(negedge clk);
      check_val("t2_dn", dn_steps - b_dn, 9);
      check_val("t2_up", up_steps - b_up, 0);
      check_val("t2_phaseupdown", phaseupdown, 0);
      check_val("t2_phase", cur_phase, 60);

      // T3: source switch only, same phase
      snap();
      do_req(1'b1, 8'd60);
      wait_done("t3_done", 4000);
      repeat (3) @(negedge clk);
      check_val("t3_sw_cycles", sw_cycles - b_sw, 4);
      check_val("t3_settle", done_cyc - sw_fall_cyc, 257);
      check_val("t3_steps", (up_steps - b_up) + (dn_steps - b_dn), 0);
      check_val("t3_src", cur_src, 1);
      check_val("t3_phase", cur_phase, 60);
      check_val("t3_err", err_timeout, 0);

      // T4: phasedone never drops
      snap();
      m_dead = 1'b1;
      do_req(1'b1, 8'd61);
      wait_done("t4_done", 4000);
      repeat (3) @(negedge clk);
      m_dead = 1'b0;
      check_val("t4_err", err_timeout, 1);
      check_val("t4_tmo_cycles", done_cyc - ps_fall_cyc, 1025);
      check_val("t4_phase", cur_phase, 60);
      check_val("t4_up", up_steps - b_up, 1);
      check_val("t4_done_cnt", done_cnt - b_done, 1);
      repeat (100) @(negedge clk);

      // T5: requests while busy, last one wins
      snap();
      do_req(1'b1, 8'd2);
      repeat (20) @(negedge clk);
      do_req(1'b1, 8'd10);
      repeat (20) @(negedge clk);
      do_req(1'b1, 8'd20);
      wait_done("t5_done1", 4000);
      check_val("t5_phase1", cur_phase, 2);
      wait_done("t5_done2", 4000);
      check_val("t5_phase2", cur_phase, 20);
      repeat (400) @(negedge clk);
      check_val("t5_done_cnt", done_cnt - b_done, 2);
      check_val("t5_up", up_steps - b_up, 24);
      check_val("t5_busy", busy, 0);
      check_val("t5_err_sticky", err_timeout, 1);

      // T6: reset while phasestep is high, then resume
      do_req(1'b1, 8'd30);
      begin
         int k;
         k = 0;
         while (!phasestep && k < 2000) begin
            @(negedge clk);
            k++;
         end
         check_val("t6_ps_seen", phasestep, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_ps_rst", phasestep, 0);
      check_val("t6_busy_rst", busy, 0);
      check_val("t6_phase_rst", cur_phase, 0);
      check_val("t6_src_rst", cur_src, 0);
      check_val("t6_err_rst", err_timeout, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (200) @(negedge clk);
      snap();
      do_req(1'b0, 8'd200);
      wait_done("t6_done_mod", 4000);
      repeat (3) @(negedge clk);
      check_val("t6_phase_mod", cur_phase, 8);
      check_val("t6_up_mod", up_steps - b_up, 8);
      snap();
      do_req(1'b0, 8'd40);
      wait_done("t6_done_tie", 4000);
      repeat (3) @(negedge clk);
      check_val("t6_up_tie", up_steps - b_up, 32);
      check_val("t6_dn_tie", dn_steps - b_dn, 0);
      check_val("t6_phase_tie", cur_phase, 40);
      check_val("t6_sw", sw_cycles - b_sw, 0);

      check_val("hold_2_rises", hold_short, 0);
      check_val("updown_stable", pud_bad, 0);
      check_val("phase_range", range_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
